// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined add/subtract unit built from GROUP-bit carry
// look-ahead groups with a second look-ahead level across the groups.
// Stage 1 registers bit/group propagate-generate terms, stage 2 resolves
// carries and flags, and a valid/ready handshake links the two stages.
// WIDTH must be a multiple of GROUP.
module cla_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / GROUP;

    // Operand preparation and stage-1 look-ahead terms (combinational)
    logic [WIDTH-1:0] b_eff;
    logic             c0_in;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;
    logic [NG-1:0]    gp_in;
    logic [NG-1:0]    gg_in;

    // Stage-1 registers
    logic             s1_valid;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [NG-1:0]    s1_gp;
    logic [NG-1:0]    s1_gg;
    logic             s1_c0;
    logic             s1_a_msb;
    logic             s1_b_msb;

    // Stage-2 combinational results
    logic [NG:0]      grp_c;
    logic [WIDTH-1:0] bit_c;
    logic [WIDTH-1:0] sum_n;
    logic             cout_n;
    logic             ovf_n;
    logic             zero_n;

    // Stage-2 registers
    logic             s2_valid;
    logic [WIDTH-1:0] s2_sum;
    logic             s2_cout;
    logic             s2_ovf;
    logic             s2_zero;

    // Handshake advance conditions
    logic             s1_adv;
    logic             s2_adv;

    // Subtraction is a + ~b + (1 - cin): invert b and the carry-in, then
    // form bit-level p/g and the per-group propagate and generate terms.
    always_comb begin : stage1_prep
        logic term;
        term  = 1'b0;
        b_eff = sub ? ~b : b;
        c0_in = sub ? ~cin : cin;
        p_in  = a ^ b_eff;
        g_in  = a & b_eff;
        gp_in = '0;
        gg_in = '0;
        for (int k = 0; k < NG; k++) begin
            gp_in[k] = &p_in[k*GROUP +: GROUP];
            for (int i = 0; i < GROUP; i++) begin
                term = g_in[k*GROUP + i];
                for (int j = i + 1; j < GROUP; j++) begin
                    term = term & p_in[k*GROUP + j];
                end
                gg_in[k] = gg_in[k] | term;
            end
        end
    end

    // A stage may advance when it is empty or its consumer is taking data
    always_comb begin : handshake
        s2_adv   = !s2_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv;
    end

    // Stage-1 register: captures look-ahead terms of an accepted beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_gp    <= '0;
            s1_gg    <= '0;
            s1_c0    <= 1'b0;
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_p     <= p_in;
                s1_g     <= g_in;
                s1_gp    <= gp_in;
                s1_gg    <= gg_in;
                s1_c0    <= c0_in;
                s1_a_msb <= a[WIDTH-1];
                s1_b_msb <= b_eff[WIDTH-1];
            end
        end
    end

    // Second-level look-ahead: every group carry is a flat sum of products
    // of group generates/propagates and c0, then each bit carry is a flat
    // look-ahead from its group's carry-in; sum and flags follow directly.
    always_comb begin : stage2_resolve
        logic term;
        logic acc;
        term     = 1'b0;
        acc      = 1'b0;
        grp_c    = '0;
        grp_c[0] = s1_c0;
        for (int k = 0; k < NG; k++) begin
            acc = s1_c0;
            for (int m = 0; m <= k; m++) begin
                acc = acc & s1_gp[m];
            end
            for (int j = 0; j <= k; j++) begin
                term = s1_gg[j];
                for (int m = j + 1; m <= k; m++) begin
                    term = term & s1_gp[m];
                end
                acc = acc | term;
            end
            grp_c[k+1] = acc;
        end
        bit_c = '0;
        for (int k = 0; k < NG; k++) begin
            for (int i = 0; i < GROUP; i++) begin
                acc = grp_c[k];
                for (int j = 0; j < i; j++) begin
                    acc = acc & s1_p[k*GROUP + j];
                end
                for (int j = 0; j < i; j++) begin
                    term = s1_g[k*GROUP + j];
                    for (int m = j + 1; m < i; m++) begin
                        term = term & s1_p[k*GROUP + m];
                    end
                    acc = acc | term;
                end
                bit_c[k*GROUP + i] = acc;
            end
        end
        sum_n  = s1_p ^ bit_c;
        cout_n = grp_c[NG];
        ovf_n  = (s1_a_msb == s1_b_msb) && (sum_n[WIDTH-1] != s1_a_msb);
        zero_n = ~|sum_n;
    end

    // Stage-2 register: holds the result until downstream accepts it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_cout  <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_zero  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum  <= sum_n;
                s2_cout <= cout_n;
                s2_ovf  <= ovf_n;
                s2_zero <= zero_n;
            end
        end
    end

    // Outputs come straight from the stage-2 registers
    always_comb begin : drive_outputs
        out_valid = s2_valid;
        sum       = s2_sum;
        cout      = s2_cout;
        ovf       = s2_ovf;
        zero      = s2_zero;
    end

endmodule
